// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: four-channel hobby-servo PWM generator.
//   Target angles arrive as a bundle over a valid/ready handshake. Each channel
//   slews its current angle toward the applied target by at most STEP_DEG once
//   per frame. Pulse widths are only reloaded at the frame boundary, so no
//   pulse is ever cut short or stretched mid-frame.
// Ports:
//   clk_100mhz, rst_n            clock, async active-low reset
//   enable                       gate all PWM outputs (re-arm at next frame)
//   target_valid/target_ready    bundle handshake
//   target_{base,shoulder,elbow,gripper}  8-bit target angles (deg)
//   servo_pwm_{base,shoulder,elbow,gripper} registered PWM pins
//   frame_start                  one-cycle pulse at start of each frame
//   busy                         some channel is still slewing

// Per-channel state: shadow/applied/current angle, width register, PWM flop.
module servo_lane #(
  parameter int unsigned MIN_PULSE_CYCLES = 100000,
  parameter int unsigned CYCLES_PER_DEG   = 556,
  parameter int unsigned ANGLE_MAX        = 180,
  parameter int unsigned CENTER_ANGLE     = 90,
  parameter int unsigned STEP_DEG         = 2
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic        accept,
  input  logic        boundary,
  input  logic        en_eff,
  input  logic [7:0]  tgt,
  input  logic [20:0] cnt,
  output logic        pwm,
  output logic        mismatch
);
  localparam logic [7:0]  CENTER = 8'(CENTER_ANGLE);
  localparam logic [7:0]  AMAX   = 8'(ANGLE_MAX);
  localparam logic [7:0]  STEP   = 8'(STEP_DEG);
  localparam logic [20:0] W_RST  = 21'(MIN_PULSE_CYCLES + CENTER_ANGLE * CYCLES_PER_DEG);

  logic [7:0]  shd, app, cur, nxt, diff, clamped;
  logic [20:0] width;

  always_comb begin
    clamped = (tgt > AMAX) ? AMAX : tgt;
    // Step toward the shadow value, since it becomes the applied target on
    // the same edge that the current angle moves.
    diff = '0;
    nxt  = cur;
    if (shd > cur) begin
      diff = shd - cur;
      nxt  = cur + ((diff > STEP) ? STEP : diff);
    end else if (shd < cur) begin
      diff = cur - shd;
      nxt  = cur - ((diff > STEP) ? STEP : diff);
    end
  end

  assign mismatch = (cur != app);

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      shd   <= CENTER;
      app   <= CENTER;
      cur   <= CENTER;
      width <= W_RST;
      pwm   <= 1'b0;
    end else begin
      // Boundary reads shd before this write, so a bundle accepted in the
      // boundary cycle waits for the following frame.
      if (accept) shd <= clamped;
      if (boundary) begin
        app   <= shd;
        cur   <= nxt;
        width <= 21'(MIN_PULSE_CYCLES) + 21'(nxt) * 21'(CYCLES_PER_DEG);
      end
      pwm <= (cnt < width) & en_eff;
    end
  end
endmodule

module servo_pwm_driver #(
  parameter int unsigned PERIOD_CYCLES    = 2000000,
  parameter int unsigned MIN_PULSE_CYCLES = 100000,
  parameter int unsigned CYCLES_PER_DEG   = 556,
  parameter int unsigned ANGLE_MAX        = 180,
  parameter int unsigned CENTER_ANGLE     = 90,
  parameter int unsigned STEP_DEG         = 2
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       target_valid,
  output logic       target_ready,
  input  logic [7:0] target_base,
  input  logic [7:0] target_shoulder,
  input  logic [7:0] target_elbow,
  input  logic [7:0] target_gripper,
  output logic       servo_pwm_base,
  output logic       servo_pwm_shoulder,
  output logic       servo_pwm_elbow,
  output logic       servo_pwm_gripper,
  output logic       frame_start,
  output logic       busy
);
  localparam int NUM_LANES = 4;
  localparam logic [20:0] CNT_LAST = 21'(PERIOD_CYCLES - 1);

  logic [20:0]                cnt;
  logic                       boundary, accept, en_eff, enable_frame;
  logic [NUM_LANES-1:0][7:0]  tgt;
  logic [NUM_LANES-1:0]       pwm, mismatch;

  assign boundary = (cnt == CNT_LAST);
  assign accept   = target_valid & target_ready;
  assign tgt      = {target_gripper, target_elbow, target_shoulder, target_base};

  // Outputs follow enable immediately on the way down, but only re-arm at a
  // frame boundary on the way up. !target_ready marks the first cycle after
  // reset, which is itself a frame start, so the first frame is not skipped.
  assign en_eff = enable & (enable_frame | ~target_ready);

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      frame_start  <= 1'b0;
      target_ready <= 1'b0;
      enable_frame <= 1'b0;
      busy         <= 1'b0;
    end else begin
      cnt          <= boundary ? '0 : cnt + 21'd1;
      frame_start  <= (cnt == '0);
      target_ready <= 1'b1;
      enable_frame <= en_eff | (enable & boundary);
      busy         <= |mismatch;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    servo_lane #(
      .MIN_PULSE_CYCLES(MIN_PULSE_CYCLES),
      .CYCLES_PER_DEG  (CYCLES_PER_DEG),
      .ANGLE_MAX       (ANGLE_MAX),
      .CENTER_ANGLE    (CENTER_ANGLE),
      .STEP_DEG        (STEP_DEG)
    ) u_lane (
      .clk_100mhz(clk_100mhz),
      .rst_n     (rst_n),
      .accept    (accept),
      .boundary  (boundary),
      .en_eff    (en_eff),
      .tgt       (tgt[i]),
      .cnt       (cnt),
      .pwm       (pwm[i]),
      .mismatch  (mismatch[i])
    );
  end

  assign servo_pwm_base     = pwm[0];
  assign servo_pwm_shoulder = pwm[1];
  assign servo_pwm_elbow    = pwm[2];
  assign servo_pwm_gripper  = pwm[3];
endmodule

// File: tb/tb_servo_pwm_driver.sv
// Bench for servo_pwm_driver with a shortened frame (600 cycles, 50 + 3*deg).
module tb_servo_pwm_driver;
  localparam int P   = 600;
  localparam int MIN = 50;
  localparam int CPD = 3;

  logic clk, rst_n, enable, target_valid, target_ready;
  logic [7:0] target_base, target_shoulder, target_elbow, target_gripper;
  logic servo_pwm_base, servo_pwm_shoulder, servo_pwm_elbow, servo_pwm_gripper;
  logic frame_start, busy;
  logic [3:0] pv;

  int total = 0, passed = 0;

  servo_pwm_driver #(.PERIOD_CYCLES(P), .MIN_PULSE_CYCLES(MIN), .CYCLES_PER_DEG(CPD)) dut (
    .clk_100mhz(clk), .rst_n(rst_n), .enable(enable),
    .target_valid(target_valid), .target_ready(target_ready),
    .target_base(target_base), .target_shoulder(target_shoulder),
    .target_elbow(target_elbow), .target_gripper(target_gripper),
    .servo_pwm_base(servo_pwm_base), .servo_pwm_shoulder(servo_pwm_shoulder),
    .servo_pwm_elbow(servo_pwm_elbow), .servo_pwm_gripper(servo_pwm_gripper),
    .frame_start(frame_start), .busy(busy)
  );

  assign pv = {servo_pwm_gripper, servo_pwm_elbow, servo_pwm_shoulder, servo_pwm_base};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit                acc;
    logic [3:0][7:0]   tgt;   // [0]=base .. [3]=gripper
    logic [3:0][20:0]  w;
    bit                bsy;
  } vec_t;

  vec_t tbl[6];

  function automatic int wd(int a);
    return MIN + CPD * a;
  endfunction

  function automatic vec_t mk(bit acc, int b, int s, int e, int g,
                              int wb, int ws, int we, int wg, bit bsy);
    vec_t v;
    v.acc = acc;
    v.tgt = {8'(g), 8'(e), 8'(s), 8'(b)};
    v.w   = {21'(wg), 21'(we), 21'(ws), 21'(wb)};
    v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic set_tgt(input logic [3:0][7:0] t);
    {target_gripper, target_elbow, target_shoulder, target_base} = t;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * P + 4; i++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_start_seen", int'(ok), 1);
  endtask

  // Samples one full frame starting at a frame_start cycle; optionally offers
  // a target bundle for one cycle early in the frame.
  task automatic measure(input bit skip, input bit acc, input logic [3:0][7:0] t,
                         output logic [3:0][20:0] w, output bit bsy);
    bit ok;
    logic [3:0] seen_low, bad, first;
    w = '0; bsy = 1'b0; ok = 1'b1;
    seen_low = '0; bad = '0; first = '0;
    if (!skip) wait_fs(ok);
    if (!ok) return;
    bsy = busy;
    for (int i = 0; i < P; i++) begin
      if (acc && i == 10) begin set_tgt(t); target_valid = 1'b1; end
      if (acc && i == 11) target_valid = 1'b0;
      if (i == 0) first = pv;
      for (int c = 0; c < 4; c++) begin
        if (pv[c]) begin
          w[c] = w[c] + 21'd1;
          if (seen_low[c]) bad[c] = 1'b1;
        end else seen_low[c] = 1'b1;
      end
      if (i < P - 1) @(negedge clk);
    end
    // all four in phase with frame_start and a single contiguous high run
    chk("pulse_shape", int'({bad, first}), 8'h0f);
  endtask

  logic [3:0][20:0] w;
  bit bsy, ok;
  int maxg, hi;
  logic [3:0][7:0] nt;

  initial begin
    rst_n = 1'b0; enable = 1'b1; target_valid = 1'b0;
    set_tgt('0);
    nt = '0;
    tbl[0] = mk(1, 100, 90, 90, 90,  320, 320, 320, 320, 0);
    tbl[1] = mk(0, 0, 0, 0, 0,       326, 320, 320, 320, 1);
    tbl[2] = mk(0, 0, 0, 0, 0,       332, 320, 320, 320, 1);
    tbl[3] = mk(0, 0, 0, 0, 0,       338, 320, 320, 320, 1);
    tbl[4] = mk(0, 0, 0, 0, 0,       344, 320, 320, 320, 1);
    tbl[5] = mk(1, 100, 90, 90, 250, 350, 320, 320, 320, 0);

    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pv), 0);
    chk("rst_ready", int'(target_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", int'(target_ready), 1);
    chk("first_frame_start", int'(frame_start), 1);

    // slew of base toward 100, then gripper bundle with out-of-range target
    for (int i = 0; i < 6; i++) begin
      measure(i == 0, tbl[i].acc, tbl[i].tgt, w, bsy);
      for (int c = 0; c < 4; c++)
        chk($sformatf("vec%0d_width_ch%0d", i, c), int'(w[c]), int'(tbl[i].w[c]));
      chk($sformatf("vec%0d_busy", i), int'(bsy), int'(tbl[i].bsy));
    end

    // gripper clamped to 180: 45 frames of +2 deg, then holds
    maxg = 0;
    for (int f = 1; f <= 47; f++) begin
      measure(0, 0, nt, w, bsy);
      if (int'(w[3]) > maxg) maxg = int'(w[3]);
      chk($sformatf("grip_f%0d", f), int'(w[3]), wd((90 + 2 * f > 180) ? 180 : 90 + 2 * f));
      chk($sformatf("grip_busy_f%0d", f), int'(bsy), (f < 45) ? 1 : 0);
    end
    chk("grip_max", maxg, 590);
    chk("base_held", int'(w[0]), 350);

    // elbow bundle accepted exactly in the boundary cycle
    wait_fs(ok);
    repeat (P - 2) @(negedge clk);
    set_tgt({8'd180, 8'd10, 8'd90, 8'd100});
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
    measure(0, 0, nt, w, bsy);
    chk("elbow_late_held", int'(w[2]), 320);
    chk("elbow_late_busy", int'(bsy), 0);
    measure(0, 0, nt, w, bsy);
    chk("elbow_step1", int'(w[2]), 314);
    chk("elbow_step1_busy", int'(bsy), 1);
    measure(0, 0, nt, w, bsy);
    chk("elbow_step2", int'(w[2]), 308);

    // enable drop mid-pulse, re-enable mid-frame
    wait_fs(ok);
    repeat (20) @(negedge clk);
    chk("pre_disable_high", int'(pv), 4'hf);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_low", int'(pv), 0);
    repeat (100) @(negedge clk);
    enable = 1'b1;
    hi = 0; ok = 1'b0;
    for (int j = 0; j < 2 * P; j++) begin
      @(negedge clk);
      if (frame_start) begin ok = 1'b1; break; end
      hi = hi | int'(pv);
    end
    chk("no_runt", hi, 0);
    chk("reenable_frame_start", int'(ok), 1);
    measure(1, 0, nt, w, bsy);
    chk("reenable_base", int'(w[0]), 350);
    chk("reenable_shoulder", int'(w[1]), 320);
    chk("reenable_elbow", int'(w[2]), 296);
    chk("reenable_gripper", int'(w[3]), 590);

    // shoulder to 120, then reset in the middle of a pulse
    wait_fs(ok);
    repeat (5) @(negedge clk);
    set_tgt({8'd180, 8'd10, 8'd120, 8'd100});
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
    for (int k = 1; k <= 14; k++) wait_fs(ok);
    measure(0, 0, nt, w, bsy);
    chk("shoulder_120", int'(w[1]), 410);
    chk("elbow_50", int'(w[2]), 200);
    chk("shoulder_busy", int'(bsy), 1);
    wait_fs(ok);
    repeat (30) @(negedge clk);
    chk("shoulder_high_before_rst", int'(pv[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pwm", int'(pv), 0);
    chk("midrst_ready", int'(target_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rerelease", int'(target_ready), 1);
    measure(1, 0, nt, w, bsy);
    for (int c = 0; c < 4; c++)
      chk($sformatf("post_rst_ch%0d", c), int'(w[c]), 320);
    chk("post_rst_busy", int'(bsy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
